// File: rtl/reorder_buffer.sv
// In-order retirement buffer with branch squash and register-file snapshot recovery.
// Optional statistics counters are built when ROB_STATS_EN is defined.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int MAX_BR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [5:0]       dispatch_rw,
  input  logic             dispatch_uses_rw,
  input  logic             dispatch_is_branch,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             complete_valid,
  input  logic [TAG_W-1:0] complete_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispredict,
  output logic [5:0]       retired_rw,
  output logic             retired_uses_rw,
  output logic             recover,
  output logic [1:0]       recover_entry,
  output logic             empty
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]      stat_retired,
  output logic [31:0]      stat_squashed
`endif
);

  localparam int BR_W = $clog2(MAX_BR + 1);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   cnt_t;
  typedef logic [BR_W-1:0]  br_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam br_t  MAX_BR_C = br_t'(MAX_BR);

  logic [DEPTH-1:0] valid_q, done_q, uses_rw_q, is_branch_q;
  logic [5:0]       rw_q      [DEPTH];
  logic [1:0]       snap_id_q [DEPTH];

  tag_t       head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d;
  logic [1:0] snap_ptr_q, snap_ptr_d;
  br_t        br_count_q, br_count_d;

  logic       retired_uses_rw_q;
  logic [5:0] retired_rw_q;
  logic       recover_q;
  logic [1:0] recover_entry_q;

  logic             alloc, retire, retire_br, mispredict;
  tag_t             age_t;
  logic [DEPTH-1:0] squash;
  cnt_t             n_squash;
  br_t              n_squash_br;

  // Only a valid branch can trigger recovery; stray resolves still block dispatch.
  assign mispredict = resolve_valid && resolve_mispredict &&
                      valid_q[resolve_tag] && is_branch_q[resolve_tag];
  assign dispatch_ready = (count_q < DEPTH_C) &&
                          !(dispatch_is_branch && br_count_q == MAX_BR_C) &&
                          !(resolve_valid && resolve_mispredict);
  assign alloc     = dispatch_valid && dispatch_ready;
  assign retire    = valid_q[head_q] && done_q[head_q];
  assign retire_br = retire && is_branch_q[head_q];
  assign age_t     = resolve_tag - head_q;

  // Entries strictly younger than the mispredicted branch; head is never among them.
  always_comb begin
    squash      = '0;
    n_squash_br = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = mispredict && valid_q[i] && (tag_t'(tag_t'(i) - head_q) > age_t);
      if (squash[i] && is_branch_q[i]) n_squash_br = n_squash_br + br_t'(1);
    end
    n_squash = mispredict ? count_q - ({1'b0, age_t} + cnt_t'(1)) : '0;
  end

  always_comb begin
    head_d     = retire ? head_q + tag_t'(1) : head_q;
    tail_d     = tail_q;
    count_d    = count_q + cnt_t'(alloc) - cnt_t'(retire);
    snap_ptr_d = snap_ptr_q;
    if (mispredict) begin
      tail_d     = resolve_tag + tag_t'(1);
      count_d    = {1'b0, age_t} + cnt_t'(1) - cnt_t'(retire);
      snap_ptr_d = snap_id_q[resolve_tag] + 2'd1;
    end else if (alloc) begin
      tail_d = tail_q + tag_t'(1);
      if (dispatch_is_branch) snap_ptr_d = snap_ptr_q + 2'd1;
    end
    br_count_d = br_count_q + br_t'(alloc && dispatch_is_branch) - n_squash_br - br_t'(retire_br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q           <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      snap_ptr_q        <= '0;
      br_count_q        <= '0;
      retired_uses_rw_q <= 1'b0;
      retired_rw_q      <= '0;
      recover_q         <= 1'b0;
      recover_entry_q   <= '0;
    end else begin
      valid_q <= valid_q & ~squash;
      if (retire) valid_q[head_q] <= 1'b0;
      if (alloc)  valid_q[tail_q] <= 1'b1;
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      snap_ptr_q        <= snap_ptr_d;
      br_count_q        <= br_count_d;
      retired_uses_rw_q <= retire && uses_rw_q[head_q];
      if (retire) retired_rw_q <= rw_q[head_q];
      recover_q <= mispredict;
      if (mispredict) recover_entry_q <= snap_id_q[resolve_tag];
    end
  end

  // NOTE: entry payload has no reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (complete_valid && complete_tag == tag_t'(i) && valid_q[i] && !squash[i])
        done_q[i] <= 1'b1;
      if (resolve_valid && resolve_tag == tag_t'(i) && valid_q[i] && is_branch_q[i])
        done_q[i] <= 1'b1;
    end
    if (alloc) begin
      done_q[tail_q]      <= 1'b0;
      uses_rw_q[tail_q]   <= dispatch_uses_rw;
      rw_q[tail_q]        <= dispatch_rw;
      is_branch_q[tail_q] <= dispatch_is_branch;
      snap_id_q[tail_q]   <= snap_ptr_q;
    end
  end

  assign dispatch_tag    = tail_q;
  assign retired_rw      = retired_rw_q;
  assign retired_uses_rw = retired_uses_rw_q;
  assign recover         = recover_q;
  assign recover_entry   = recover_entry_q;
  assign empty           = (count_q == '0);

`ifdef ROB_STATS_EN
  logic [31:0] stat_retired_q, stat_squashed_q;
  logic [32:0] squashed_sum;

  assign squashed_sum = {1'b0, stat_squashed_q} + 33'(n_squash);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_retired_q  <= '0;
      stat_squashed_q <= '0;
    end else begin
      if (retire && stat_retired_q != '1) stat_retired_q <= stat_retired_q + 32'd1;
      stat_squashed_q <= squashed_sum[32] ? '1 : squashed_sum[31:0];
    end
  end

  assign stat_retired  = stat_retired_q;
  assign stat_squashed = stat_squashed_q;
`endif

endmodule
